// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB-lite bus arbiter.
//   htrans_e / hburst_e : AHB transfer-type and burst-type encodings
//   burst_beats()       : beat count of a burst type (0 = undefined-length INCR)
//   HRESP_OKAY/ERROR    : slave response encodings
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Wide enough for beats-1 of the longest defined burst (16 beats)
    localparam int unsigned BEAT_CNT_W = 4;

    // Number of beats in a burst; 0 marks the undefined-length INCR burst
    function automatic int burst_beats(hburst_e burst);
        int beats;
        case (burst)
            HBURST_SINGLE:                beats = 1;
            HBURST_WRAP4,  HBURST_INCR4:  beats = 4;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 8;
            HBURST_WRAP16, HBURST_INCR16: beats = 16;
            default:                      beats = 0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_arb_burst_cnt.sv
// Remaining-beat counter for a defined-length burst.
//   hclk, hreset : clock, asynchronous active-high reset
//   load/load_val: load beats-1 when the NONSEQ of a burst is accepted
//   dec          : one SEQ beat accepted
//   clr          : abandon the burst (ERROR response)
//   last_beat_c  : the SEQ currently on the bus is the final beat
module ahb_arb_burst_cnt
    import ahb_arb_pkg::*;
(
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  load,
    input  logic [BEAT_CNT_W-1:0] load_val,
    input  logic                  dec,
    input  logic                  clr,
    output logic                  last_beat_c
);

    logic [BEAT_CNT_W-1:0] count_q;

    // Clear has priority so an ERROR always wins over a coincident load
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - BEAT_CNT_W'(1);
        end
    end

    // One SEQ left means the beat now on the bus closes the burst
    assign last_beat_c = (count_q == BEAT_CNT_W'(1));

endmodule

// File: rtl/ahb_lite_bus_arbiter.sv
// AHB-lite arbiter: shares one slave port between NUM_MASTERS masters.
// Grants the address phase, muxes the owner's address/control and the
// data-phase owner's write data, and never splits a defined-length burst.
// Configuration: define AHB_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins); otherwise round-robin starting after the current owner.
// Ports:
//   hclk, hreset                       clock, asynchronous active-high reset
//   m_hbusreq / m_hgrant               per-master request / one-hot grant
//   m_haddr..m_hwdata                  per-master packed bus signals
//   hsel,haddr,htrans,hwrite,hsize,hburst,hwdata  slave-side bus
//   hready, hresp, hrdata              slave response
//   m_hready, m_hresp, m_hrdata        slave response fanned out to masters
//   hmaster                            address-phase owner index
module ahb_lite_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS = 2,
    parameter  int unsigned ADDR_WIDTH  = 32,
    parameter  int unsigned DATA_WIDTH  = 32,
    localparam int unsigned MIDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              hclk,
    input  logic                              hreset,
    input  logic [NUM_MASTERS-1:0]            m_hbusreq,
    output logic [NUM_MASTERS-1:0]            m_hgrant,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr,
    input  logic [NUM_MASTERS*2-1:0]          m_htrans,
    input  logic [NUM_MASTERS-1:0]            m_hwrite,
    input  logic [NUM_MASTERS*3-1:0]          m_hsize,
    input  logic [NUM_MASTERS*3-1:0]          m_hburst,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata,
    output logic                              hsel,
    output logic [ADDR_WIDTH-1:0]             haddr,
    output logic [1:0]                        htrans,
    output logic                              hwrite,
    output logic [2:0]                        hsize,
    output logic [2:0]                        hburst,
    output logic [DATA_WIDTH-1:0]             hwdata,
    input  logic                              hready,
    input  logic [1:0]                        hresp,
    input  logic [DATA_WIDTH-1:0]             hrdata,
    output logic                              m_hready,
    output logic [1:0]                        m_hresp,
    output logic [DATA_WIDTH-1:0]             m_hrdata,
    output logic [MIDX_W-1:0]                 hmaster
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [MIDX_W-1:0]       hmaster_d;
    logic [MIDX_W-1:0]       data_owner_q;
    logic [NUM_MASTERS-1:0]  grant_d;
    logic                    sel_req;
    htrans_e                 sel_trans;
    hburst_e                 sel_burst;
    htrans_e                 bus_trans;
    logic [MIDX_W-1:0]       winner;
    logic                    found;
    logic                    rearb;
    logic                    cnt_load;
    logic                    cnt_dec;
    logic                    cnt_clr;
    logic                    cnt_last;
    logic [BEAT_CNT_W-1:0]   cnt_load_val;

    // Slave response is shared by every master
    assign m_hready = hready;
    assign m_hresp  = hresp;
    assign m_hrdata = hrdata;

    // Address/control mux from the address-phase owner
    always_comb begin
        sel_req   = m_hbusreq[hmaster];
        sel_trans = htrans_e'(m_htrans[hmaster*2 +: 2]);
        sel_burst = hburst_e'(m_hburst[hmaster*3 +: 3]);
        // A non-requesting owner (or reset) must not start a transfer
        bus_trans = (sel_req && !hreset) ? sel_trans : HTRANS_IDLE;
        hsel      = sel_req && !hreset;
        htrans    = bus_trans;
        haddr     = m_haddr[hmaster*ADDR_WIDTH +: ADDR_WIDTH];
        hwrite    = m_hwrite[hmaster];
        hsize     = m_hsize[hmaster*3 +: 3];
        hburst    = m_hburst[hmaster*3 +: 3];
        hwdata    = m_hwdata[data_owner_q*DATA_WIDTH +: DATA_WIDTH];
    end

    // Winner selection; master 0 is the default when nobody requests
    always_comb begin
        winner = '0;
        found  = 1'b0;
`ifdef AHB_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!found && m_hbusreq[MIDX_W'(i)]) begin
                winner = MIDX_W'(i);
                found  = 1'b1;
            end
        end
`else
        // Search starts after the owner, so the owner ranks last
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            if (!found && m_hbusreq[MIDX_W'((32'(hmaster) + i) % NUM_MASTERS)]) begin
                winner = MIDX_W'((32'(hmaster) + i) % NUM_MASTERS);
                found  = 1'b1;
            end
        end
`endif
    end

    // Next-state / arbitration control
    always_comb begin
        state_d      = state_q;
        hmaster_d    = hmaster;
        grant_d      = m_hgrant;
        rearb        = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_clr      = 1'b0;
        cnt_load_val = BEAT_CNT_W'(burst_beats(sel_burst) - 1);

        if (hresp == HRESP_ERROR) begin
            // Master may cancel; release the burst lock and arbitrate once ready
            cnt_clr = 1'b1;
            state_d = ST_ARB;
            rearb   = hready;
        end else if (hready) begin
            case (state_q)
                ST_ARB: begin
                    if (bus_trans == HTRANS_NONSEQ && burst_beats(sel_burst) > 1) begin
                        state_d  = ST_BURST;
                        cnt_load = 1'b1;
                    end else begin
                        rearb = 1'b1;
                    end
                end
                ST_BURST: begin
                    // BUSY and IDLE beats do not consume the burst
                    if (bus_trans == HTRANS_SEQ) begin
                        cnt_dec = 1'b1;
                        if (cnt_last) begin
                            state_d = ST_ARB;
                            rearb   = 1'b1;
                        end
                    end
                end
                default: state_d = ST_ARB;
            endcase
        end

        if (rearb) begin
            hmaster_d          = winner;
            grant_d            = '0;
            grant_d[winner]    = 1'b1;
        end
    end

    // State, grant and data-phase owner registers
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q      <= ST_ARB;
            hmaster      <= '0;
            m_hgrant     <= NUM_MASTERS'(1);
            data_owner_q <= '0;
        end else begin
            state_q  <= state_d;
            hmaster  <= hmaster_d;
            m_hgrant <= grant_d;
            if (hready) begin
                data_owner_q <= hmaster;
            end
        end
    end

    ahb_arb_burst_cnt u_burst_cnt (
        .hclk        (hclk),
        .hreset      (hreset),
        .load        (cnt_load),
        .load_val    (cnt_load_val),
        .dec         (cnt_dec),
        .clr         (cnt_clr),
        .last_beat_c (cnt_last)
    );

endmodule

// File: tb/tb_ahb_lite_bus_arbiter.sv
// Scoreboard bench for ahb_lite_bus_arbiter (two masters).
module tb_ahb_lite_bus_arbiter;
    import ahb_arb_pkg::*;

    localparam int unsigned NM = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef AHB_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam logic [31:0] WDATA0 = 32'hD0D0_0000;
    localparam logic [31:0] WDATA1 = 32'hD1D1_0001;

    typedef struct {
        int unsigned m;
        logic [31:0] a;
        logic [1:0]  t;
        logic        w;
    } beat_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        req   [NM];
    logic [1:0]  trans [NM];
    logic [31:0] addr  [NM];
    logic        wr    [NM];
    logic [2:0]  burst [NM];

    logic [NM-1:0]    m_hbusreq, m_hgrant, m_hwrite;
    logic [NM*AW-1:0] m_haddr;
    logic [NM*2-1:0]  m_htrans;
    logic [NM*3-1:0]  m_hsize, m_hburst;
    logic [NM*DW-1:0] m_hwdata;
    logic             hsel, hwrite, hready, m_hready;
    logic [AW-1:0]    haddr;
    logic [1:0]       htrans, hresp, m_hresp;
    logic [2:0]       hsize, hburst;
    logic [DW-1:0]    hwdata, hrdata, m_hrdata;
    logic [0:0]       hmaster;

    beat_t       sb[$];
    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic        pend_v  = 1'b0;
    logic [31:0] pend_d  = '0;

    assign m_hbusreq = {req[1], req[0]};
    assign m_htrans  = {trans[1], trans[0]};
    assign m_haddr   = {addr[1], addr[0]};
    assign m_hwrite  = {wr[1], wr[0]};
    assign m_hburst  = {burst[1], burst[0]};
    assign m_hsize   = {3'b010, 3'b010};
    assign m_hwdata  = {WDATA1, WDATA0};
    assign hrdata    = 32'h5A5A_A5A5;

    always #5 hclk = ~hclk;

    ahb_lite_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .hclk(hclk), .hreset(hreset),
        .m_hbusreq(m_hbusreq), .m_hgrant(m_hgrant), .m_haddr(m_haddr),
        .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hwdata(m_hwdata),
        .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata),
        .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
        .hmaster(hmaster)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic push(input int unsigned m, input logic [31:0] a, input logic [1:0] t, input logic w);
        beat_t b;
        b.m = m; b.a = a; b.t = t; b.w = w;
        sb.push_back(b);
    endtask

    task automatic drive(input int unsigned m, input logic [1:0] t, input logic [31:0] a,
                         input logic [2:0] b, input logic w);
        req[m] = 1'b1; trans[m] = t; addr[m] = a; burst[m] = b; wr[m] = w;
    endtask

    task automatic idle(input int unsigned m);
        req[m] = 1'b0; trans[m] = HTRANS_IDLE; burst[m] = HBURST_SINGLE; wr[m] = 1'b0;
    endtask

    // Master m issues one SINGLE as soon as it owns the address phase
    task automatic single_xfer(input int unsigned m, input logic [31:0] a, input logic w);
        bit got = 1'b0;
        drive(m, HTRANS_NONSEQ, a, HBURST_SINGLE, w);
        for (int i = 0; i < 16 && !got; i++) begin
            if (32'(hmaster) == m && hready) begin
                push(m, a, HTRANS_NONSEQ, w);
                got = 1'b1;
            end
            step();
        end
        idle(m);
        if (!got) begin
            n_total++;
            $display("FAIL grant_timeout: master %0d never granted, expected a grant within 16 cycles", m);
        end
    endtask

    // Monitor: data-phase and accepted address-phase beats against the scoreboard
    always @(negedge hclk) begin
        beat_t e;
        if (hreset) begin
            pend_v = 1'b0;
        end else if (hready) begin
            if (pend_v) begin
                check("hwdata", 64'(hwdata), 64'(pend_d));
                pend_v = 1'b0;
            end
            if (hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got haddr 0x%0h from master %0d, expected no transfer", haddr, hmaster);
                end else begin
                    e = sb.pop_front();
                    check("beat_hmaster", 64'(hmaster), 64'(e.m));
                    check("beat_haddr",   64'(haddr),   64'(e.a));
                    check("beat_htrans",  64'(htrans),  64'(e.t));
                    check("beat_hwrite",  64'(hwrite),  64'(e.w));
                    if (e.w) begin
                        pend_v = 1'b1;
                        pend_d = (e.m == 0) ? WDATA0 : WDATA1;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        hreset = 1'b1; hready = 1'b1; hresp = HRESP_OKAY;
        for (int m = 0; m < NM; m++) begin addr[m] = '0; idle(m); end
        // Reset holds the bus idle even with a requesting default master
        drive(0, HTRANS_NONSEQ, 32'h0000_0040, HBURST_INCR4, 1'b1);
        step(); step();
        check("rst_hgrant",  64'(m_hgrant), 64'(2'b01));
        check("rst_hmaster", 64'(hmaster),  64'(0));
        check("rst_htrans",  64'(htrans),   64'(HTRANS_IDLE));
        check("rst_hsel",    64'(hsel),     64'(0));
        idle(0);
        step();
        hreset = 1'b0;
        step();

        // INCR4 by M0 is not split by a competing M1 request; write handover
        drive(0, HTRANS_NONSEQ, 32'h100, HBURST_INCR4, 1'b1);
        drive(1, HTRANS_NONSEQ, 32'h200, HBURST_SINGLE, 1'b1);
        push(0, 32'h100, HTRANS_NONSEQ, 1'b1);
        step();
        for (int k = 1; k < 4; k++) begin
            drive(0, HTRANS_SEQ, 32'h100 + 32'(4 * k), HBURST_INCR4, 1'b1);
            push(0, 32'h100 + 32'(4 * k), HTRANS_SEQ, 1'b1);
            check("incr4_grant_held", 64'(hmaster), 64'(0));
            step();
        end
        check("incr4_handover_hmaster", 64'(hmaster),  64'(FIXED ? 0 : 1));
        check("incr4_handover_hgrant",  64'(m_hgrant), 64'(FIXED ? 2'b01 : 2'b10));
        check("handover_hwdata_old",    64'(hwdata),   64'(WDATA0));
        idle(0);
        single_xfer(1, 32'h200, 1'b1);
        check("handover_hwdata_new",    64'(hwdata),   64'(WDATA1));
        step();
        check("idle_default_master", 64'(hmaster), 64'(0));

        // WRAP8 with a three-cycle wait state in the middle
        drive(0, HTRANS_NONSEQ, 32'h300, HBURST_WRAP8, 1'b1);
        drive(1, HTRANS_NONSEQ, 32'h400, HBURST_SINGLE, 1'b0);
        push(0, 32'h300, HTRANS_NONSEQ, 1'b1);
        step();
        for (int k = 1; k < 8; k++) begin
            drive(0, HTRANS_SEQ, 32'h300 + 32'(4 * k), HBURST_WRAP8, 1'b1);
            if (k == 3) begin
                hready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    check("stall_hmaster", 64'(hmaster),  64'(0));
                    check("stall_hgrant",  64'(m_hgrant), 64'(2'b01));
                    check("stall_hwdata",  64'(hwdata),   64'(WDATA0));
                end
                hready = 1'b1;
            end
            push(0, 32'h300 + 32'(4 * k), HTRANS_SEQ, 1'b1);
            step();
        end
        check("wrap8_end_hmaster", 64'(hmaster), 64'(FIXED ? 0 : 1));
        idle(0);
        single_xfer(1, 32'h400, 1'b0);
        step();
        check("idle_default_master2", 64'(hmaster), 64'(0));

        // Both masters issue SINGLE reads continuously
        drive(0, HTRANS_NONSEQ, 32'h500, HBURST_SINGLE, 1'b0);
        drive(1, HTRANS_NONSEQ, 32'h600, HBURST_SINGLE, 1'b0);
        for (int i = 0; i < 4; i++) begin
            int unsigned em;
            em = FIXED ? 0 : 32'(i % 2);
            check("single_alt_hmaster", 64'(hmaster), 64'(em));
            push(em, (em == 0) ? 32'h500 : 32'h600, HTRANS_NONSEQ, 1'b0);
            step();
        end
        idle(0); idle(1);
        step(); step();
        check("idle_default_master3", 64'(hmaster), 64'(0));

        // ERROR on beat 2 of INCR16 releases the burst lock
        drive(0, HTRANS_NONSEQ, 32'h700, HBURST_INCR16, 1'b1);
        drive(1, HTRANS_NONSEQ, 32'h800, HBURST_SINGLE, 1'b1);
        push(0, 32'h700, HTRANS_NONSEQ, 1'b1);
        step();
        drive(0, HTRANS_SEQ, 32'h704, HBURST_INCR16, 1'b1);
        push(0, 32'h704, HTRANS_SEQ, 1'b1);
        step();
        drive(0, HTRANS_SEQ, 32'h708, HBURST_INCR16, 1'b1);
        hready = 1'b0; hresp = HRESP_ERROR;
        step();
        hready = 1'b1;
        idle(0);
        step();
        hresp = HRESP_OKAY;
        check("error_hmaster", 64'(hmaster),  64'(1));
        check("error_hgrant",  64'(m_hgrant), 64'(2'b10));
        single_xfer(1, 32'h800, 1'b1);

        // Reset asserted on beat 3 of an INCR8 owned by M1
        check("pre_reset_hmaster", 64'(hmaster), 64'(1));
        drive(1, HTRANS_NONSEQ, 32'h900, HBURST_INCR8, 1'b0);
        push(1, 32'h900, HTRANS_NONSEQ, 1'b0);
        step();
        drive(1, HTRANS_SEQ, 32'h904, HBURST_INCR8, 1'b0);
        push(1, 32'h904, HTRANS_SEQ, 1'b0);
        step();
        drive(1, HTRANS_SEQ, 32'h908, HBURST_INCR8, 1'b0);
        #1 hreset = 1'b1;
        #1;
        check("midburst_rst_hgrant",  64'(m_hgrant), 64'(2'b01));
        check("midburst_rst_hmaster", 64'(hmaster),  64'(0));
        check("midburst_rst_htrans",  64'(htrans),   64'(HTRANS_IDLE));
        check("midburst_rst_hsel",    64'(hsel),     64'(0));
        step();
        idle(1);
        step();
        hreset = 1'b0;
        drive(1, HTRANS_NONSEQ, 32'hA00, HBURST_SINGLE, 1'b0);
        step();
        check("post_reset_handover", 64'(hmaster), 64'(1));
        single_xfer(1, 32'hA00, 1'b0);
        step(); step();

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
